// File: rtl/main_memory_pkg.sv
// Shared definitions for the main_memory block: FSM encoding, default sizing,
// and the out-of-range address helper.
package main_memory_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int DEFAULT_DEPTH_WORDS = 1024;
    localparam int DEFAULT_LATENCY     = 4;
    localparam int COUNT_W             = 4;

    // An address is out of range when any bit above the word index is set.
    function automatic logic addr_out_of_range(input logic [31:0] addr, input int index_w);
        return (addr >> (index_w + 2)) != 32'd0;
    endfunction

endpackage

// File: rtl/main_memory_array.sv
// Single-port word storage: synchronous write, synchronous registered read.
// The read register only changes on a read, a clear or a reset.
module main_memory_array
    import main_memory_pkg::*;
#(
    parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          we,
    input  logic          clr,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem_r [DEPTH_WORDS] = '{default: 32'd0};

    // Array write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (en && we) begin
            mem_r[addr] <= wdata;
        end
    end

    // Read register: loads on a read, zeroes on clear or reset, otherwise holds.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata <= 32'd0;
        end else if (clr) begin
            rdata <= 32'd0;
        end else if (en && !we) begin
            rdata <= mem_r[addr];
        end else begin
            rdata <= rdata;
        end
    end

endmodule

// File: rtl/main_memory.sv
// Fixed-latency main memory model for a cache. Optional out-of-range address
// checking is compiled in with MAIN_MEMORY_RANGE_CHECK_EN.
module main_memory
    import main_memory_pkg::*;
#(
    parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
    parameter int LATENCY     = DEFAULT_LATENCY
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] memoryAddress,
    input  logic        memoryReadEnable,
    input  logic        memoryWriteEnable,
    input  logic [31:0] memoryDataOut,
    output logic [31:0] memoryDataIn,
    output logic        memoryReady
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [COUNT_W-1:0] COUNT_LOAD = COUNT_W'(LATENCY - 1);

    state_t             state_r;
    state_t             state_next_s;
    logic [COUNT_W-1:0] count_r;
    logic [AW-1:0]      index_r;
    logic [31:0]        wdata_r;
    logic               write_r;
    logic               oob_r;
    logic               oob_in_s;
    logic               ready_r;
    logic               ready_next_s;
    logic               start_s;
    logic               access_s;
    logic               mem_en_s;
    logic               mem_clr_s;

`ifdef MAIN_MEMORY_RANGE_CHECK_EN
    assign oob_in_s = addr_out_of_range(memoryAddress, AW);
`else
    logic addr_unused_s;
    assign oob_in_s      = 1'b0;
    assign addr_unused_s = ^{memoryAddress[31:AW+2], memoryAddress[1:0]};
`endif

    assign start_s  = (state_r == IDLE) && (memoryReadEnable || memoryWriteEnable);
    // Reset on the access edge must abandon the access, including the write.
    assign access_s = (state_r == BUSY) && (count_r == {COUNT_W{1'b0}}) && !reset;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_s) state_next_s = BUSY;
                else         state_next_s = IDLE;
            end
            BUSY: begin
                if (count_r == {COUNT_W{1'b0}}) state_next_s = RESP;
                else                            state_next_s = BUSY;
            end
            RESP:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Output and array-control decode.
    always_comb begin
        ready_next_s = 1'b0;
        mem_en_s     = 1'b0;
        mem_clr_s    = 1'b0;
        case (state_next_s)
            RESP:    ready_next_s = 1'b1;
            default: ready_next_s = 1'b0;
        endcase
        if (access_s) begin
            mem_en_s  = !oob_r;
            mem_clr_s = oob_r && !write_r;
        end else begin
            mem_en_s  = 1'b0;
            mem_clr_s = 1'b0;
        end
    end

    // Request capture and latency countdown; read wins when both enables are high.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= {COUNT_W{1'b0}};
            index_r <= {AW{1'b0}};
            wdata_r <= 32'd0;
            write_r <= 1'b0;
            oob_r   <= 1'b0;
        end else if (start_s) begin
            count_r <= COUNT_LOAD;
            index_r <= memoryAddress[AW+1:2];
            wdata_r <= memoryDataOut;
            write_r <= memoryWriteEnable && !memoryReadEnable;
            oob_r   <= oob_in_s;
        end else if ((state_r == BUSY) && (count_r != {COUNT_W{1'b0}})) begin
            count_r <= count_r - {{(COUNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    // Completion pulse register.
    always_ff @(posedge clk) begin
        if (reset) begin
            ready_r <= 1'b0;
        end else begin
            ready_r <= ready_next_s;
        end
    end

    assign memoryReady = ready_r;

    main_memory_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .clk   (clk),
        .reset (reset),
        .en    (mem_en_s),
        .we    (write_r),
        .clr   (mem_clr_s),
        .addr  (index_r),
        .wdata (wdata_r),
        .rdata (memoryDataIn)
    );

endmodule
